// File: rtl/stall_controller.sv
// Pipeline stall/flush controller: per-latch enables and clears from memory
// handshakes and hazards, plus stall accounting and a sticky stall watchdog.
module stall_controller #(
    parameter int NSTAGES = 5,
    parameter int REGW    = 5,
    parameter int CW      = 16,
    parameter int TOUT    = 255
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ihit,
    input  logic               dreq,
    input  logic               dhit,
    input  logic               ex_memread,
    input  logic [REGW-1:0]    ex_rd,
    input  logic [REGW-1:0]    de_rs,
    input  logic [REGW-1:0]    de_rt,
    input  logic               branch_taken,
    input  logic               halt,
    output logic [NSTAGES-1:0] en,
    output logic [NSTAGES-1:0] flush,
    output logic [1:0]         state,
    output logic [CW-1:0]      stall_cnt,
    output logic               timeout
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        IWAIT  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int          M       = NSTAGES - 2;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] TOUT_C  = CW'(TOUT);

    state_t               state_q, state_d;
    logic [CW-1:0]        stall_cnt_q, stall_cnt_d;
    logic [CW-1:0]        consec_q, consec_d;
    logic                 timeout_q, timeout_d;
    logic [NSTAGES-1:0]   en_c, flush_c;
    logic                 lu;
    logic                 stall;

    assign lu = ex_memread && (ex_rd != '0) && ((ex_rd == de_rs) || (ex_rd == de_rt));

    // Enables and clears are a zero-latency function of inputs and the registered state.
    always_comb begin
        en_c    = '0;
        flush_c = '0;
        state_d = state_q;
        if (RST) begin
            state_d = RUN;
        end else if (state_q == HALTED) begin
            state_d = HALTED;
        end else begin
            if (dreq && !dhit) begin
                state_d = DWAIT;
            end else if (dreq && dhit && !ihit) begin
                en_c[NSTAGES-1] = 1'b1;
                flush_c[M]      = 1'b1;
                state_d         = IWAIT;
            end else if (!dreq && !ihit) begin
                state_d = IWAIT;
            end else if (ihit && branch_taken) begin
                en_c       = '1;
                flush_c[1] = 1'b1;
                flush_c[2] = 1'b1;
                state_d    = RUN;
            end else if (ihit && lu) begin
                en_c       = '1;
                en_c[0]    = 1'b0;
                en_c[1]    = 1'b0;
                flush_c[2] = 1'b1;
                state_d    = RUN;
            end else begin
                en_c    = '1;
                state_d = RUN;
            end
            // A halt that leaves MEM/WB this cycle freezes the pipe for good.
            if (halt && en_c[NSTAGES-1]) begin
                state_d = HALTED;
            end
        end
    end

    assign stall = !RST && (state_q != HALTED) && !en_c[0];

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        consec_d    = consec_q;
        timeout_d   = timeout_q;
        if (stall) begin
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (consec_q != CNT_MAX) begin
                consec_d = consec_q + 1'b1;
            end
            if (consec_d == TOUT_C) begin
                timeout_d = 1'b1;
            end
        end else if (en_c[0]) begin
            consec_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            consec_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            consec_q    <= consec_d;
            timeout_q   <= timeout_d;
        end
    end

    assign en        = en_c;
    assign flush     = flush_c;
    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_stall_controller.sv
// Directed bench for stall_controller (NSTAGES=5, TOUT=4, CW=4) with an
// expectation queue popped and checked mid-cycle.
module tb_stall_controller;

    localparam int NSTAGES = 5;
    localparam int REGW    = 5;
    localparam int CW      = 4;
    localparam int TOUT    = 4;

    localparam logic [1:0] S_RUN = 2'd0, S_DWAIT = 2'd1, S_IWAIT = 2'd2, S_HALTED = 2'd3;

    logic               CLK = 1'b0;
    logic               RST, ihit, dreq, dhit, ex_memread, branch_taken, halt;
    logic [REGW-1:0]    ex_rd, de_rs, de_rt;
    logic [NSTAGES-1:0] en, flush;
    logic [1:0]         state;
    logic [CW-1:0]      stall_cnt;
    logic               timeout;

    typedef struct {
        string              tag;
        logic [NSTAGES-1:0] en;
        logic [NSTAGES-1:0] flush;
        logic [1:0]         state;
        logic [CW-1:0]      cnt;
        logic               to;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    stall_controller #(.NSTAGES(NSTAGES), .REGW(REGW), .CW(CW), .TOUT(TOUT)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dreq(dreq), .dhit(dhit),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .de_rs(de_rs), .de_rt(de_rt),
        .branch_taken(branch_taken), .halt(halt), .en(en), .flush(flush),
        .state(state), .stall_cnt(stall_cnt), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    // Push the expectation for the cycle just driven, check it at the falling
    // edge, then advance past the next rising edge.
    task automatic step(input string tag, input logic [NSTAGES-1:0] e_en,
                        input logic [NSTAGES-1:0] e_fl, input logic [1:0] e_st,
                        input logic [CW-1:0] e_cnt, input logic e_to);
        exp_t e;
        exp_t got;
        e.tag = tag; e.en = e_en; e.flush = e_fl; e.state = e_st; e.cnt = e_cnt; e.to = e_to;
        sb.push_back(e);
        @(negedge CLK);
        got = sb.pop_front();
        tests++;
        assert (en === got.en) else begin
            fails++; $error("FAIL %s en observed=%b expected=%b", got.tag, en, got.en);
        end
        tests++;
        assert (flush === got.flush) else begin
            fails++; $error("FAIL %s flush observed=%b expected=%b", got.tag, flush, got.flush);
        end
        tests++;
        assert (state === got.state) else begin
            fails++; $error("FAIL %s state observed=%0d expected=%0d", got.tag, state, got.state);
        end
        tests++;
        assert (stall_cnt === got.cnt) else begin
            fails++; $error("FAIL %s stall_cnt observed=%0d expected=%0d", got.tag, stall_cnt, got.cnt);
        end
        tests++;
        assert (timeout === got.to) else begin
            fails++; $error("FAIL %s timeout observed=%b expected=%b", got.tag, timeout, got.to);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dreq = 1'b0; dhit = 1'b0; ex_memread = 1'b0; branch_taken = 1'b0;
        halt = 1'b0; ex_rd = '0; de_rs = '0; de_rt = '0;
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        @(posedge CLK);
        #1;

        // Reset dominates outputs whatever the other inputs do
        branch_taken = 1'b1;
        step("reset_hold", 5'b00000, 5'b00000, S_RUN, 4'd0, 1'b0);

        // Data miss for 3 cycles, then instruction miss, then resume
        RST = 1'b0; idle_inputs();
        ihit = 1'b0; dreq = 1'b1; dhit = 1'b0;
        step("dmiss1", 5'b00000, 5'b00000, S_RUN,   4'd0, 1'b0);
        step("dmiss2", 5'b00000, 5'b00000, S_DWAIT, 4'd1, 1'b0);
        step("dmiss3", 5'b00000, 5'b00000, S_DWAIT, 4'd2, 1'b0);
        dhit = 1'b1;
        step("dhit_imiss", 5'b10000, 5'b01000, S_DWAIT, 4'd3, 1'b0);
        ihit = 1'b1;
        step("resume", 5'b11111, 5'b00000, S_IWAIT, 4'd4, 1'b1);
        idle_inputs();
        step("run_after", 5'b11111, 5'b00000, S_RUN, 4'd4, 1'b1);

        RST = 1'b1;
        step("reset_a", 5'b00000, 5'b00000, S_RUN, 4'd4, 1'b1);

        // Load-use hazards and the ex_rd == 0 exemption
        RST = 1'b0; idle_inputs();
        ex_memread = 1'b1; ex_rd = 5'd3; de_rt = 5'd3; de_rs = 5'd7;
        step("lu_rt", 5'b11100, 5'b00100, S_RUN, 4'd0, 1'b0);
        ex_rd = 5'd0; de_rt = 5'd0;
        step("lu_r0", 5'b11111, 5'b00000, S_RUN, 4'd1, 1'b0);
        ex_rd = 5'd5; de_rs = 5'd5; de_rt = 5'd9;
        step("lu_rs", 5'b11100, 5'b00100, S_RUN, 4'd1, 1'b0);
        branch_taken = 1'b1;
        step("br_lu", 5'b11111, 5'b00110, S_RUN, 4'd2, 1'b0);
        dreq = 1'b1; dhit = 1'b0;
        step("dmiss_over_br", 5'b00000, 5'b00000, S_RUN, 4'd2, 1'b0);
        idle_inputs();
        step("dwait_release", 5'b11111, 5'b00000, S_DWAIT, 4'd3, 1'b0);

        RST = 1'b1; dreq = 1'b1; dhit = 1'b0;
        step("reset_b", 5'b00000, 5'b00000, S_RUN, 4'd3, 1'b0);

        // Watchdog: consecutive instruction misses, then saturation of stall_cnt
        RST = 1'b0; idle_inputs(); ihit = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step($sformatf("wd%0d", k), 5'b00000, 5'b00000, (k == 1) ? S_RUN : S_IWAIT,
                 CW'(k - 1), (k - 1 >= TOUT) ? 1'b1 : 1'b0);
        end
        ihit = 1'b1;
        step("wd_resume", 5'b11111, 5'b00000, S_IWAIT, 4'd5, 1'b1);
        ihit = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step($sformatf("sat%0d", j), 5'b00000, 5'b00000, (j == 1) ? S_RUN : S_IWAIT,
                 CW'((5 + j - 1 > 15) ? 15 : (5 + j - 1)), 1'b1);
        end
        ihit = 1'b1;
        step("sat_end", 5'b11111, 5'b00000, S_IWAIT, 4'd15, 1'b1);

        // Reset mid-stall clears everything
        ihit = 1'b0;
        step("stall_pre_rst", 5'b00000, 5'b00000, S_RUN, 4'd15, 1'b1);
        RST = 1'b1;
        step("reset_c", 5'b00000, 5'b00000, S_IWAIT, 4'd15, 1'b1);

        // Halt only takes effect when MEM/WB is enabled
        RST = 1'b0; idle_inputs();
        halt = 1'b1; dreq = 1'b1; dhit = 1'b0;
        step("halt_blocked", 5'b00000, 5'b00000, S_RUN, 4'd0, 1'b0);
        dhit = 1'b1; ihit = 1'b0;
        step("halt_memwb", 5'b10000, 5'b01000, S_DWAIT, 4'd1, 1'b0);
        idle_inputs();
        step("halted_ihit", 5'b00000, 5'b00000, S_HALTED, 4'd2, 1'b0);
        ihit = 1'b0; dreq = 1'b1;
        step("halted_miss", 5'b00000, 5'b00000, S_HALTED, 4'd2, 1'b0);
        step("halted_hold", 5'b00000, 5'b00000, S_HALTED, 4'd2, 1'b0);
        RST = 1'b1;
        step("reset_halted", 5'b00000, 5'b00000, S_HALTED, 4'd2, 1'b0);
        RST = 1'b0; idle_inputs(); halt = 1'b1;
        step("halt_run", 5'b11111, 5'b00000, S_RUN, 4'd0, 1'b0);
        halt = 1'b0;
        step("halted_again", 5'b00000, 5'b00000, S_HALTED, 4'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stall_controller.md
STALL_CONTROLLER -- requirements
Module: stall_controller

Interface
REQ-001 SHALL provide parameter NSTAGES, default 5: number of pipeline latches controlled; legal range 5..8. Latch 0 is the PC, latch NSTAGES-1 is MEM/WB, and M = NSTAGES-2 is EX/MEM.
REQ-002 SHALL provide parameter REGW, default 5: register-address width.
REQ-003 SHALL provide parameter CW, default 16: stall-counter width.
REQ-004 SHALL provide parameter TOUT, default 255: consecutive-stall timeout threshold, 1..2^CW-1.
REQ-005 Ports SHALL be as follows. One clock; reset is synchronous and active-high.
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- ihit  in  1  instruction fetch complete this cycle
- dreq  in  1  load/store present in MEM stage
- dhit  in  1  data access complete this cycle
- ex_memread  in  1  EX-stage instruction is a load
- ex_rd  in  REGW  EX-stage destination register
- de_rs, de_rt  in  REGW each  decode-stage source registers
- branch_taken  in  1  EX-stage branch/jump redirect
- halt  in  1  halt instruction in MEM/WB latch
- en  out  NSTAGES  per-latch enable
- flush  out  NSTAGES  per-latch synchronous clear
- state  out  2  current FSM state
- stall_cnt  out  CW  total stall cycles
- timeout  out  1  sticky watchdog flag

Function
REQ-006 FSM states SHALL be RUN=0, DWAIT=1, IWAIT=2, HALTED=3; state SHALL be registered.
REQ-007 en and flush SHALL be combinational from the inputs and the registered state, with zero latency.
REQ-008 Define lu = ex_memread & (ex_rd != 0) & (ex_rd == de_rs | ex_rd == de_rt).
REQ-009 Rules for RUN, DWAIT and IWAIT SHALL be identical and evaluated in priority order (a) to (f):
- (a) dreq & ~dhit: en = 0, flush = 0; next state DWAIT.
- (b) dreq & dhit & ~ihit: en[NSTAGES-1] = 1, all other en = 0; flush[M] = 1; next state IWAIT.
- (c) ~dreq & ~ihit: en = 0, flush = 0; next state IWAIT.
- (d) ihit & branch_taken: en = all 1; flush[1] = flush[2] = 1; next state RUN.
- (e) ihit & lu: en[0] = en[1] = 0, all other en = 1; flush[2] = 1; next state RUN.
- (f) otherwise: en = all 1, flush = 0; next state RUN.
REQ-010 Branch (d) SHALL take priority over load-use (e) in the same cycle.
REQ-011 If halt = 1 and en[NSTAGES-1] = 1 in a cycle, the next state SHALL be HALTED, overriding REQ-009.
REQ-012 HALTED: en = 0 and flush = 0; the FSM SHALL stay in HALTED until RST.
REQ-013 A stall cycle is any cycle, outside HALTED and outside RST, with en[0] = 0.
- stall_cnt SHALL increment by 1 per stall cycle.
- stall_cnt SHALL saturate at 2^CW-1, with no wrap.
REQ-014 An internal consecutive-stall counter SHALL increment on each stall cycle and clear on any cycle with en[0] = 1.
- timeout SHALL set on the clock edge at which this counter reaches TOUT.
- timeout SHALL stay set until RST, including if stalls continue or the FSM halts.
REQ-015 Inputs SHALL be ignored in HALTED, except RST.
REQ-016 Expected size: 120-400 lines of RTL.

Reset
REQ-017 With RST = 1 at a rising CLK edge, the next state SHALL be: state = RUN, stall_cnt = 0, consecutive counter = 0, timeout = 0.
REQ-018 While RST = 1, en SHALL be 0 and flush SHALL be 0, regardless of the other inputs.
REQ-019 Asserting RST mid-stall or in HALTED SHALL apply REQ-017 at the next edge, with no residual state.
REQ-020 The first cycle after RST deasserts SHALL evaluate REQ-009 from RUN.

Verification (NSTAGES = 5, TOUT = 4, CW = 4)
REQ-021 Data miss then instruction miss: dreq = 1, dhit = 0 for 3 cycles, then dhit = 1, ihit = 0 for 1 cycle, then ihit = 1.
- Expected: en = 00000 and state DWAIT for 3 cycles.
- Then en = 10000, flush = 01000, state becomes IWAIT.
- Then en = 11111 and state RUN.
- stall_cnt = 4.
REQ-022 Load-use: ihit = 1, ex_memread = 1, ex_rd = 3, de_rt = 3 -> en = 11100, flush = 00100. Same stimulus with ex_rd = 0 -> en = 11111, flush = 00000.
REQ-023 Branch with load-use: ihit = 1, branch_taken = 1, lu true -> en = 11111, flush = 00110.
REQ-024 Watchdog: ihit = 0 for 5 cycles -> timeout = 1 after the 4th edge. Then ihit = 1 -> timeout stays 1, stall_cnt = 5. Then 20 more stall cycles -> stall_cnt saturates at 15.
REQ-025 Halt and reset: ihit = 1, halt = 1 -> state HALTED at the next edge and en = 00000 thereafter, regardless of ihit. RST for 1 cycle -> state RUN, counters 0, timeout 0.
